// File: rtl/scan_chain_controller_pkg.sv
// Shared types for the scan chain controller.
// Holds the FSM state encoding and the default chain length.
package scan_chain_controller_pkg;

  localparam int SCAN_CHAIN_LEN = 16;

  typedef enum logic [2:0] {
    SCAN_IDLE      = 3'd0,
    SCAN_SHIFT_IN  = 3'd1,
    SCAN_CAPTURE   = 3'd2,
    SCAN_SHIFT_OUT = 3'd3,
    SCAN_FINISH    = 3'd4
  } scan_state_e;

endpackage

// File: rtl/scan_chain_controller_if.sv
// Scan controller bundle: START/ABORT/PATTERN/EXPECT requests,
// SCAN_TE/TI/SO chain wires, BUSY/DONE/RESULT/PASS status.
interface scan_chain_controller_if
  import scan_chain_controller_pkg::*;
#(
  parameter int CHAIN_LEN = SCAN_CHAIN_LEN
);

  logic                 START;
  logic                 ABORT;
  logic [CHAIN_LEN-1:0] PATTERN;
  logic [CHAIN_LEN-1:0] EXPECT;
  logic                 SCAN_SO;
  logic                 SCAN_TE;
  logic                 SCAN_TI;
  logic                 BUSY;
  logic                 DONE;
  logic [CHAIN_LEN-1:0] RESULT;
  logic                 PASS;

  // Test register block plus chain side.
  modport master (
    output START, ABORT, PATTERN, EXPECT, SCAN_SO,
    input  SCAN_TE, SCAN_TI, BUSY, DONE, RESULT, PASS
  );

  // Controller side.
  modport slave (
    input  START, ABORT, PATTERN, EXPECT, SCAN_SO,
    output SCAN_TE, SCAN_TI, BUSY, DONE, RESULT, PASS
  );

endinterface

// File: rtl/scan_shift_reg.sv
// Shift register: parallel load, serial in at LSB, MSB serial out.
// Ports: clk, rst, load/din, shift/si, q (parallel), so (MSB).
module scan_shift_reg
  import scan_chain_controller_pkg::*;
#(
  parameter int WIDTH = SCAN_CHAIN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             so
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], si};
    end
  end

  assign so = q[WIDTH-1];

endmodule

// File: rtl/scan_chain_controller.sv
// Scan chain driver: shifts PATTERN in, pulses one capture, unloads
// and compares. Ports: CLK, RST, bus (slave modport of the bundle).
module scan_chain_controller
  import scan_chain_controller_pkg::*;
#(
  parameter int CHAIN_LEN = SCAN_CHAIN_LEN,
  parameter int CNT_W     = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  scan_chain_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  scan_state_e state_q;
  scan_state_e state_d;

  logic [CNT_W-1:0]     cnt_q;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] res_q;
  logic                 pass_q;

  logic [CHAIN_LEN-1:0] pat_q;
  logic [CHAIN_LEN-1:0] cap_q;
  logic [CHAIN_LEN-1:0] cap_next;
  logic                 pat_so;
  logic                 cap_so;

  logic pat_load;
  logic pat_shift;
  logic cap_load;
  logic cap_shift;
  logic cnt_clr;
  logic cnt_inc;
  logic res_upd;

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_pat_sr (
    .clk   (CLK),
    .rst   (RST),
    .load  (pat_load),
    .din   (bus.PATTERN),
    .shift (pat_shift),
    .si    (1'b0),
    .q     (pat_q),
    .so    (pat_so)
  );

  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_cap_sr (
    .clk   (CLK),
    .rst   (RST),
    .load  (cap_load),
    .din   ('0),
    .shift (cap_shift),
    .si    (bus.SCAN_SO),
    .q     (cap_q),
    .so    (cap_so)
  );

  // Response including the sample taken on the final unload edge.
  assign cap_next = {cap_q[CHAIN_LEN-2:0], bus.SCAN_SO};

  always_comb begin
    state_d   = state_q;
    pat_load  = 1'b0;
    pat_shift = 1'b0;
    cap_load  = 1'b0;
    cap_shift = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    res_upd   = 1'b0;
    unique case (state_q)
      SCAN_IDLE: begin
        if (bus.START && !bus.ABORT) begin
          state_d  = SCAN_SHIFT_IN;
          pat_load = 1'b1;
          cap_load = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      SCAN_SHIFT_IN: begin
        if (bus.ABORT) begin
          state_d = SCAN_IDLE;
        end else begin
          pat_shift = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt_q == LAST) state_d = SCAN_CAPTURE;
        end
      end
      SCAN_CAPTURE: begin
        if (bus.ABORT) begin
          state_d = SCAN_IDLE;
        end else begin
          cnt_clr = 1'b1;
          state_d = SCAN_SHIFT_OUT;
        end
      end
      SCAN_SHIFT_OUT: begin
        if (bus.ABORT) begin
          state_d = SCAN_IDLE;
        end else begin
          cap_shift = 1'b1;
          cnt_inc   = 1'b1;
          if (cnt_q == LAST) begin
            state_d = SCAN_FINISH;
            res_upd = 1'b1;
          end
        end
      end
      SCAN_FINISH: state_d = SCAN_IDLE;
      default:     state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= SCAN_IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (pat_load) exp_q <= bus.EXPECT;
      if (res_upd) begin
        res_q  <= cap_next;
        pass_q <= (cap_next == exp_q);
      end
    end
  end

  assign bus.SCAN_TE = (state_q == SCAN_SHIFT_IN) ||
                       (state_q == SCAN_SHIFT_OUT);
  assign bus.SCAN_TI = (state_q == SCAN_SHIFT_IN) && pat_so;
  assign bus.BUSY    = (state_q != SCAN_IDLE);
  assign bus.DONE    = (state_q == SCAN_FINISH);
  assign bus.RESULT  = res_q;
  assign bus.PASS    = pass_q;

  // Parallel view of pat_sr and serial view of cap_sr are not needed.
  logic unused_sr;
  assign unused_sr = ^{pat_q, cap_q[CHAIN_LEN-1], cap_so};

endmodule

// File: tb/tb_scan_chain_controller.sv
// Scoreboard bench for scan_chain_controller with a 4-flop
// scan-with-set chain model; random runs plus directed corner cases.
module tb_scan_chain_controller;

  localparam int N = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  bit   clk_en = 1'b0;

  scan_chain_controller_if #(.CHAIN_LEN(N)) bus ();

  scan_chain_controller #(.CHAIN_LEN(N), .CNT_W(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always begin
    #5;
    if (clk_en) CLK = ~CLK;
  end

  // Chain: TI of flop k from Q of flop k-1, set inputs inactive.
  logic [N-1:0] chain_q = '0;
  logic [N-1:0] chain_d = '0;
  always @(posedge CLK)
    chain_q <= bus.SCAN_TE ? {chain_q[N-2:0], bus.SCAN_TI} : chain_d;
  assign bus.SCAN_SO = chain_q[N-1];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  logic [N:0]   res_sb[$];
  logic [N-1:0] pat_sb[$];
  logic [N-1:0] last_res = '0;
  logic         last_pass = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: result on DONE, loaded chain contents in the capture cycle.
  always @(negedge CLK) begin
    if (!RST && bus.DONE) begin
      done_cnt++;
      check("done_expected", 32'(res_sb.size() != 0), 1);
      if (res_sb.size() != 0) begin
        logic [N:0] e;
        e = res_sb.pop_front();
        check("result", 32'(bus.RESULT), 32'(e[N-1:0]));
        check("pass", 32'(bus.PASS), 32'(e[N]));
      end
    end
    if (!RST && bus.BUSY && !bus.SCAN_TE && !bus.DONE) begin
      check("capture_expected", 32'(pat_sb.size() != 0), 1);
      if (pat_sb.size() != 0)
        check("chain_load", 32'(chain_q), 32'(pat_sb.pop_front()));
    end
  end

  task automatic run(input logic [N-1:0] pat, input logic [N-1:0] d,
                     input logic [N-1:0] ex, input int abort_c,
                     input bit extra, input bit rst_mid);
    int k;
    int d0;
    chain_d     = d;
    bus.PATTERN = pat;
    bus.EXPECT  = ex;
    bus.START   = 1'b1;
    pat_sb.push_back(pat);
    res_sb.push_back({d == ex, d});
    d0 = done_cnt;
    tick();
    bus.START = 1'b0;
    check("busy_start", 32'(bus.BUSY), 1);
    check("te_shift_in", 32'(bus.SCAN_TE), 1);
    check("ti_first", 32'(bus.SCAN_TI), 32'(pat[N-1]));
    if (abort_c > 0) begin
      for (int i = 1; i < abort_c; i++) tick();
      bus.ABORT = 1'b1;
      tick();
      bus.ABORT = 1'b0;
      check("abort_te", 32'(bus.SCAN_TE), 0);
      check("abort_busy", 32'(bus.BUSY), 0);
      if (abort_c <= N) void'(pat_sb.pop_back());
      void'(res_sb.pop_back());
      repeat (2 * N + 4) tick();
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_result", 32'(bus.RESULT), 32'(last_res));
      check("abort_pass", 32'(bus.PASS), 32'(last_pass));
    end else if (rst_mid) begin
      repeat (N + 2) tick();
      check("pre_rst_te", 32'(bus.SCAN_TE), 1);
      #2 RST = 1'b1;
      #1;
      check("rst_te", 32'(bus.SCAN_TE), 0);
      check("rst_ti", 32'(bus.SCAN_TI), 0);
      check("rst_busy", 32'(bus.BUSY), 0);
      check("rst_done", 32'(bus.DONE), 0);
      check("rst_result", 32'(bus.RESULT), 0);
      check("rst_pass", 32'(bus.PASS), 0);
      void'(res_sb.pop_back());
      tick();
      tick();
      RST       = 1'b0;
      last_res  = '0;
      last_pass = 1'b0;
      repeat (2 * N + 4) tick();
      check("rst_no_done", done_cnt - d0, 0);
      check("rst_idle", 32'(bus.BUSY), 0);
    end else begin
      k = 0;
      while (!bus.DONE && k < 40) begin
        tick();
        k++;
        if (extra) bus.START = (k == N + 3);
      end
      check("done_latency", k, 2 * N + 1);
      if (extra) bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
      check("done_one_cycle", 32'(bus.DONE), 0);
      check("idle_after_done", 32'(bus.BUSY), 0);
      tick();
      check("done_count", done_cnt - d0, 1);
      last_res  = d;
      last_pass = (d == ex);
      check("result_hold", 32'(bus.RESULT), 32'(d));
      check("pass_hold", 32'(bus.PASS), 32'(d == ex));
    end
  endtask

  initial begin
    logic [N-1:0] p;
    logic [N-1:0] d;
    logic [N-1:0] e;
    int mode;
    bus.START   = 1'b0;
    bus.ABORT   = 1'b0;
    bus.PATTERN = '0;
    bus.EXPECT  = '0;

    #1 RST = 1'b1;
    #1;
    check("reset_te", 32'(bus.SCAN_TE), 0);
    check("reset_ti", 32'(bus.SCAN_TI), 0);
    check("reset_busy", 32'(bus.BUSY), 0);
    check("reset_done", 32'(bus.DONE), 0);
    check("reset_result", 32'(bus.RESULT), 0);
    check("reset_pass", 32'(bus.PASS), 0);

    clk_en = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();

    run(4'b1011, 4'b0110, 4'b0110, 0, 1'b0, 1'b0);
    run(4'b1011, 4'b0110, 4'b0111, 0, 1'b0, 1'b0);
    run(4'b1011, 4'b0110, 4'b0110, 3, 1'b0, 1'b0);
    run(4'b1011, 4'b0110, 4'b0110, 0, 1'b1, 1'b0);
    run(4'b0101, 4'b1001, 4'b1001, 0, 1'b0, 1'b0);

    // START with ABORT in IDLE must not launch a run.
    bus.START = 1'b1;
    bus.ABORT = 1'b1;
    tick();
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    check("start_abort_idle", 32'(bus.BUSY), 0);
    tick();

    run(4'b1110, 4'b0011, 4'b0011, 0, 1'b0, 1'b1);
    tick();

    for (int i = 0; i < 40; i++) begin
      p    = N'($urandom);
      d    = N'($urandom);
      e    = ($urandom_range(0, 1) == 1) ? d : N'($urandom);
      mode = $urandom_range(0, 5);
      if (mode == 0)
        run(p, d, e, $urandom_range(1, 2 * N + 1), 1'b0, 1'b0);
      else if (mode == 1)
        run(p, d, e, 0, 1'b1, 1'b0);
      else
        run(p, d, e, 0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (5) tick();
    check("scoreboard_empty", res_sb.size() + pat_sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
